// File: rtl/memoria_programa_burst_pkg.sv
// ti170_pkg: shared constants for the TI170 program memory and fetch path.
// Holds the default widths, the out-of-range fill word, the fetch FSM state enum
// and a few opcode constants used when building program images.
package ti170_pkg;

  localparam int         TI_DATA_W       = 8;
  localparam int         TI_ADDR_W       = 8;
  localparam logic [7:0] TI_DEFAULT_WORD = 8'h00;

  // TI170 opcodes used in boot images and bench programs
  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_BRA     = 8'h20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } fetch_st_e;

endpackage

// File: rtl/memoria_programa_burst_if.sv
// Fetch request/response bus between the decode unit (master) and the program
// memory (slave). Requests carry a start address and a word count; responses
// return one word per valid/ready beat, flagged with last and err.
interface memoria_programa_burst_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 3
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_last;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_len, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_last, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_len, resp_ready,
    output req_ready, resp_valid, resp_data, resp_last, resp_err
  );

endinterface

// File: rtl/memoria_programa_burst_prog_mem_array.sv
// prog_mem_array: DEPTH x DATA_W program store with one registered read port.
// Default build is a ROM whose contents come from the packed INIT_IMAGE
// parameter (word i at bits [i*DATA_W +: DATA_W]). With PROG_WRITE_EN defined
// the store becomes a RAM written through a single write port; its contents are
// not reset and are expected to be programmed by the boot loader.
module prog_mem_array #(
  parameter int                      DATA_W     = 8,
  parameter int                      DEPTH      = 128,
  parameter int                      IDX_W      = $clog2(DEPTH),
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMAGE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
`ifdef PROG_WRITE_EN
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
`endif
  input  logic              unused_tie_i
);

  logic [DATA_W-1:0] rd_q;

`ifdef PROG_WRITE_EN
  logic [DATA_W-1:0] mem_q [DEPTH];

  // loader write; storage deliberately has no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  // registered read; holds its value while rd_en is low so a stalled word stays put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_q <= '0;
    else if (rd_en) rd_q <= mem_q[rd_idx];
  end
`else
  logic [DATA_W-1:0] rom_w [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom_w[i] = INIT_IMAGE[i*DATA_W +: DATA_W];
  end

  // registered read; holds its value while rd_en is low so a stalled word stays put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_q <= '0;
    else if (rd_en) rd_q <= rom_w[rd_idx];
  end
`endif

  assign rd_data = rd_q;

  // spare input kept tied low at the instance; folds into nothing
  logic unused_w;
  assign unused_w = unused_tie_i;

endmodule

// File: rtl/memoria_programa_burst.sv
// memoria_programa_burst: synchronous burst-fetch program memory for TI170.
// Accepts (addr, len) requests and streams len words (0 -> 1, clamped to
// MAX_BURST) at one word per cycle with a registered read and read-ahead.
// Out-of-range addresses return DEFAULT_WORD with resp_err set; addresses wrap
// modulo 2**ADDR_W. Contents come from INIT_IMAGE.
// Optional macro PROG_WRITE_EN adds the ld_* loader port (writes only in IDLE,
// and a loader write holds off request acceptance that cycle).
module memoria_programa_burst
  import ti170_pkg::*;
#(
  parameter int                      DATA_W       = TI_DATA_W,
  parameter int                      ADDR_W       = TI_ADDR_W,
  parameter int                      DEPTH        = 128,
  parameter int                      MAX_BURST    = 4,
  parameter int                      LEN_W        = 3,
  parameter logic [DATA_W-1:0]       DEFAULT_WORD = DATA_W'(TI_DEFAULT_WORD),
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMAGE   = {DEPTH{DEFAULT_WORD}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  memoria_programa_burst_if.slave  bus,
`ifdef PROG_WRITE_EN
  input  logic                     ld_we,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
`endif
  output logic                     busy
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [LEN_W-1:0] MAXB_C  = LEN_W'(MAX_BURST);

  fetch_st_e         st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;   // address of the next word to read ahead
  logic [LEN_W-1:0]  rem_q, rem_d;     // words still to come after the presented one
  logic              err_q, err_d;     // presented word was out of range

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              ld_hit;
  logic              adv, last, accept;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0)    return LEN_W'(1);
    if (len > MAXB_C) return MAXB_C;
    return len;
  endfunction

`ifdef PROG_WRITE_EN
  logic wr_en;
  assign ld_hit = ld_we && (st_q == ST_IDLE);
  assign wr_en  = ld_hit && in_range(ld_addr);
`else
  assign ld_hit = 1'b0;
`endif

  assign last   = (rem_q == '0);
  assign adv    = (st_q == ST_BURST) && bus.resp_ready;
  // ready in IDLE, and also while the last word is being taken so a new request
  // can chain without a gap; held low in reset and on a loader beat
  assign bus.req_ready = rst_n && !ld_hit && ((st_q == ST_IDLE) || (adv && last));
  assign accept = bus.req_valid && bus.req_ready;

  // next-state: advance on an accepted word, restart on an accepted request
  always_comb begin
    st_d    = st_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    case (st_q)
      ST_IDLE: ;
      ST_BURST: begin
        if (adv) begin
          if (last) begin
            st_d = ST_IDLE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = addr_q;
            err_d   = !in_range(addr_q);
            addr_d  = addr_q + ADDR_W'(1);
            rem_d   = rem_q - LEN_W'(1);
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (accept) begin
      st_d    = ST_BURST;
      rd_en   = 1'b1;
      rd_addr = bus.req_addr;
      err_d   = !in_range(bus.req_addr);
      addr_d  = bus.req_addr + ADDR_W'(1);
      rem_d   = clamp_len(bus.req_len) - LEN_W'(1);
    end
  end

  // state and burst bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      rem_q  <= rem_d;
      err_q  <= err_d;
    end
  end

  prog_mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W),
    .INIT_IMAGE (INIT_IMAGE)
  ) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en && in_range(rd_addr)),
    .rd_idx       (rd_addr[IDX_W-1:0]),
    .rd_data      (rd_data),
`ifdef PROG_WRITE_EN
    .wr_en        (wr_en),
    .wr_idx       (ld_addr[IDX_W-1:0]),
    .wr_data      (ld_data),
`endif
    .unused_tie_i (1'b0)
  );

  // the read register is only updated for in-range words, so err_q selects the fill
  assign bus.resp_valid = (st_q == ST_BURST);
  assign bus.resp_data  = err_q ? DEFAULT_WORD : rd_data;
  assign bus.resp_last  = (st_q == ST_BURST) && last;
  assign bus.resp_err   = (st_q == ST_BURST) && err_q;
  assign busy           = (st_q == ST_BURST);

endmodule
